bank_lane_reader: RTL and testbench
===================================

BANK_LANE_READER -- requirements
Module: bank_lane_reader

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 4, number of read banks (2..16).
REQ-002 SHALL have parameter BANK_W, default 32, bits per bank word.
REQ-003 SHALL have parameter LANE_W, default 8, bits per output lane; BANK_W a multiple of LANE_W; LANES = BANK_W/LANE_W.
REQ-004 SHALL have parameter MAX_LEN, default 16, maximum burst length in lanes.
REQ-005 wb_clk_i  in  1  sole clock; all logic is rising-edge.
REQ-006 wb_rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-007 bank_rdata_i  in  NUM_BANKS*BANK_W  flattened bank words; bank k occupies bits [k*BANK_W +: BANK_W].
REQ-008 req_valid_i  in  1  burst request valid.
REQ-009 req_ready_o  out  1  block can accept a request.
REQ-010 req_bank_i  in  clog2(NUM_BANKS)  start bank.
REQ-011 req_lane_i  in  clog2(LANES)  start lane.
REQ-012 req_len_i  in  clog2(MAX_LEN)+1  burst length in lanes.
REQ-013 out_valid_o  out  1  out_data_o valid.
REQ-014 out_ready_i  in  1  consumer accepts out_data_o.
REQ-015 out_data_o  out  LANE_W  selected lane.
REQ-016 out_last_o  out  1  final lane of burst.
REQ-017 err_o  out  1  one-cycle pulse on rejected request.

Function
REQ-018 SHALL implement FSM states IDLE, BURST.
REQ-019 req_ready_o SHALL equal 1 only in IDLE.
REQ-020 Request accepted when req_valid_i && req_ready_o; IDLE->BURST unless rejected.
REQ-021 Request SHALL be rejected (stay IDLE, err_o=1 next cycle, no output) if req_len_i==0, req_len_i>MAX_LEN, or req_bank_i>=NUM_BANKS.
REQ-022 Cursor (bank, lane) and remaining count SHALL load from the request on acceptance.
REQ-023 Output register SHALL load bank_rdata_i lane[cursor] (lane 0 = bits [LANE_W-1:0]) when empty or when out_valid_o && out_ready_i; first out_valid_o one cycle after acceptance.
REQ-024 bank_rdata_i SHALL be sampled at the cycle each lane is loaded, not at acceptance.
REQ-025 After each load, lane increments; lane LANES-1 wraps to 0 and bank increments; bank NUM_BANKS-1 wraps to 0.
REQ-026 out_data_o, out_last_o SHALL hold stable while out_valid_o && !out_ready_i.
REQ-027 out_last_o SHALL be 1 exactly on the lane where remaining count reaches 1.
REQ-028 On handshake of the last lane: BURST->IDLE, out_valid_o deasserts next cycle unless another burst load occurs; req_ready_o 1 that same next cycle.
REQ-029 With out_ready_i held 1, throughput SHALL be one lane per cycle; burst of N lanes occupies N+1 cycles from acceptance to IDLE.
REQ-030 req_* inputs SHALL be ignored in BURST; no queuing.

Reset
REQ-031 Reset SHALL force IDLE, out_valid_o=0, out_data_o=0, out_last_o=0, err_o=0, req_ready_o=1, cursor and count=0.
REQ-032 Reset mid-burst SHALL abandon the burst immediately; no residual output after release.

Structure
REQ-033 Shared package bank_reader_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-034 One sub-module natural: bank_lane_sel (combinational NUM_BANKS x LANES lane selector), instantiated once.

Verification
REQ-035 Defaults, banks = 0x44332211, 0x88776655, 0xCCBBAA99, 0x00FFEEDD; req bank0 lane0 len4, ready=1 -> 0x11,0x22,0x33,0x44, last on 0x44.
REQ-036 req bank3 lane2 len4 -> 0xFF,0x00,0x11,0x22 (bank wrap 3->0), last on 0x22.
REQ-037 len3 from bank1 lane0, out_ready_i low cycles 2-4 -> 0x55 held stable, then 0x66,0x77; no drop/duplicate.
REQ-038 req_len_i=0, then 17 -> err_o pulse each, out_valid_o stays 0, req_ready_o stays 1.
REQ-039 wb_rst_ni low during lane 2 of len8 burst -> outputs zero asynchronously; after release req_ready_o=1, no output until new request.
REQ-040 NUM_BANKS=3 build, req_bank_i=3 -> err_o pulse; bank2 lane3 len2 wraps to bank0 lane0.

Source files
------------

// File: rtl/bank_reader_pkg.sv
// Shared definitions for the banked lane reader: default sizing and FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   DEF_*    default parameter values used by bank_lane_reader and bank_lane_sel
//   state_e  burst controller state encoding
//   idx_w    width of an index able to address n items (minimum 1 bit)
package bank_reader_pkg;

    localparam int DEF_NUM_BANKS = 4;
    localparam int DEF_BANK_W    = 32;
    localparam int DEF_LANE_W    = 8;
    localparam int DEF_MAX_LEN   = 16;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    // A single-item space still needs a 1-bit index so that ports never
    // collapse to zero width.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bank_lane_sel.sv
// Combinational selector: picks one LANE_W lane out of NUM_BANKS x LANES bank words.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows the inputs.
//
// Ports:
//   bank_rdata  flattened bank words, bank k at [k*BANK_W +: BANK_W]
//   bank, lane  cursor; lane 0 is the least significant LANE_W bits of a word
//   lane_data   selected lane; zero if bank is outside 0..NUM_BANKS-1
module bank_lane_sel
    import bank_reader_pkg::*;
#(
    parameter int  NUM_BANKS = DEF_NUM_BANKS,
    parameter int  BANK_W    = DEF_BANK_W,
    parameter int  LANE_W    = DEF_LANE_W,
    localparam int LANES     = BANK_W / LANE_W,
    localparam int BANK_IW   = idx_w(NUM_BANKS),
    localparam int LANE_IW   = idx_w(LANES)
)(
    input  logic [NUM_BANKS*BANK_W-1:0] bank_rdata,
    input  logic [BANK_IW-1:0]          bank,
    input  logic [LANE_IW-1:0]          lane,
    output logic [LANE_W-1:0]           lane_data
);

    always_comb begin
        lane_data = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int l = 0; l < LANES; l++) begin
                if (bank == BANK_IW'(b) && lane == LANE_IW'(l)) begin
                    lane_data = bank_rdata[b*BANK_W + l*LANE_W +: LANE_W];
                end
            end
        end
    end

endmodule

// File: rtl/bank_lane_reader.sv
// Burst reader: streams req_len_i lanes starting at (bank, lane), walking lanes then banks with wrap.
// Latency: first lane valid 1 cycle after acceptance; 1 lane/cycle; N-lane burst back in IDLE after N+1 cycles.
// Backpressure: output register holds data/last while out_ready_i is low; req_ready_o low for the whole burst.
//
// Ports:
//   wb_clk_i, wb_rst_ni          clock, async active-low reset
//   bank_rdata_i                 flattened bank words, sampled when each lane is loaded
//   req_valid_i/req_ready_o      request handshake; req_bank_i, req_lane_i, req_len_i describe the burst
//   out_valid_o/out_ready_i      output handshake; out_data_o lane, out_last_o marks final lane
//   err_o                        one-cycle pulse after a rejected request
module bank_lane_reader
    import bank_reader_pkg::*;
#(
    parameter int  NUM_BANKS = DEF_NUM_BANKS,
    parameter int  BANK_W    = DEF_BANK_W,
    parameter int  LANE_W    = DEF_LANE_W,
    parameter int  MAX_LEN   = DEF_MAX_LEN,
    localparam int LANES     = BANK_W / LANE_W,
    localparam int BANK_IW   = idx_w(NUM_BANKS),
    localparam int LANE_IW   = idx_w(LANES),
    localparam int LEN_W     = $clog2(MAX_LEN) + 1
)(
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_ni,
    input  logic [NUM_BANKS*BANK_W-1:0] bank_rdata_i,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic [BANK_IW-1:0]          req_bank_i,
    input  logic [LANE_IW-1:0]          req_lane_i,
    input  logic [LEN_W-1:0]            req_len_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [LANE_W-1:0]           out_data_o,
    output logic                        out_last_o,
    output logic                        err_o
);

    localparam logic [LEN_W-1:0]   MAX_LEN_L   = LEN_W'(MAX_LEN);
    localparam logic [BANK_IW:0]   NUM_BANKS_L = (BANK_IW + 1)'(NUM_BANKS);
    localparam logic [BANK_IW-1:0] LAST_BANK   = BANK_IW'(NUM_BANKS - 1);
    localparam logic [LANE_IW-1:0] LAST_LANE   = LANE_IW'(LANES - 1);

    state_e              state_q;
    logic [BANK_IW-1:0]  cur_bank_q;
    logic [LANE_IW-1:0]  cur_lane_q;
    // Lanes still to be loaded after the one currently in the output register.
    logic [LEN_W-1:0]    rem_q;
    logic                out_valid_q;
    logic [LANE_W-1:0]   out_data_q;
    logic                out_last_q;
    logic                err_q;

    logic                req_fire;
    logic                req_bad;
    logic                req_ok;
    logic                out_fire;
    logic                burst_load;
    logic                do_load;
    logic [BANK_IW-1:0]  sel_bank;
    logic [LANE_IW-1:0]  sel_lane;
    logic [LANE_W-1:0]   sel_data;
    logic [BANK_IW-1:0]  nxt_bank;
    logic [LANE_IW-1:0]  nxt_lane;
    logic [LEN_W-1:0]    load_rem;
    logic                load_last;

    assign req_ready_o = (state_q == ST_IDLE);
    assign req_fire    = req_valid_i && req_ready_o;
    assign req_bad     = (req_len_i == '0) || (req_len_i > MAX_LEN_L) ||
                         ({1'b0, req_bank_i} >= NUM_BANKS_L);
    assign req_ok      = req_fire && !req_bad;
    assign out_fire    = out_valid_q && out_ready_i;
    // Inside a burst the output register is always full, so the only load
    // opportunity is a handshake on a non-final lane.
    assign burst_load  = (state_q == ST_BURST) && out_fire && !out_last_q;
    assign do_load     = req_ok || burst_load;

    // On acceptance the first lane comes straight from the request fields so
    // that data is valid one cycle later; afterwards the stored cursor drives.
    always_comb begin
        sel_bank  = cur_bank_q;
        sel_lane  = cur_lane_q;
        load_rem  = rem_q - LEN_W'(1);
        load_last = (rem_q == LEN_W'(1));
        if (state_q == ST_IDLE) begin
            sel_bank  = req_bank_i;
            sel_lane  = req_lane_i;
            load_rem  = req_len_i - LEN_W'(1);
            load_last = (req_len_i == LEN_W'(1));
        end
    end

    // Cursor advance: lane first, then bank, both wrapping.
    always_comb begin
        nxt_lane = sel_lane + LANE_IW'(1);
        nxt_bank = sel_bank;
        if (sel_lane == LAST_LANE) begin
            nxt_lane = '0;
            nxt_bank = (sel_bank == LAST_BANK) ? '0 : sel_bank + BANK_IW'(1);
        end
    end

    bank_lane_sel #(
        .NUM_BANKS (NUM_BANKS),
        .BANK_W    (BANK_W),
        .LANE_W    (LANE_W)
    ) u_sel (
        .bank_rdata (bank_rdata_i),
        .bank       (sel_bank),
        .lane       (sel_lane),
        .lane_data  (sel_data)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= ST_IDLE;
            cur_bank_q  <= '0;
            cur_lane_q  <= '0;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q <= req_fire && req_bad;

            if (do_load) begin
                state_q     <= ST_BURST;
                out_valid_q <= 1'b1;
                out_data_q  <= sel_data;
                out_last_q  <= load_last;
                cur_bank_q  <= nxt_bank;
                cur_lane_q  <= nxt_lane;
                rem_q       <= load_rem;
            end else if ((state_q == ST_BURST) && out_fire) begin
                // Final lane consumed: back to IDLE, output register empties.
                state_q     <= ST_IDLE;
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_bank_lane_reader.sv
module tb_bank_lane_reader;

    localparam int NB    = 4;
    localparam int LANES = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Default build (4 banks)
    logic [NB*32-1:0] bank_rdata;
    logic             req_valid, req_ready;
    logic [1:0]       req_bank, req_lane;
    logic [4:0]       req_len;
    logic             out_valid, out_ready, out_last, err;
    logic [7:0]       out_data;

    // 3-bank build
    logic [95:0]      bank_rdata3;
    logic             req_valid3, req_ready3;
    logic [1:0]       req_bank3, req_lane3;
    logic [4:0]       req_len3;
    logic             out_valid3, out_ready3, out_last3, err3;
    logic [7:0]       out_data3;

    bank_lane_reader dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .bank_rdata_i(bank_rdata),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_bank_i(req_bank),
        .req_lane_i(req_lane), .req_len_i(req_len), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .out_data_o(out_data), .out_last_o(out_last), .err_o(err)
    );

    bank_lane_reader #(.NUM_BANKS(3)) dut3 (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .bank_rdata_i(bank_rdata3),
        .req_valid_i(req_valid3), .req_ready_o(req_ready3), .req_bank_i(req_bank3),
        .req_lane_i(req_lane3), .req_len_i(req_len3), .out_valid_o(out_valid3),
        .out_ready_i(out_ready3), .out_data_o(out_data3), .out_last_o(out_last3), .err_o(err3)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] bank_w     [NB];
    logic [31:0] bank_w_new [NB];
    logic [7:0]  exp_d [$];
    logic [7:0]  got_d [$];
    logic        got_l [$];
    int          hold_viol, busy_rdy, cyc_cnt;
    bit          timeout, acc_rdy, first_vld, end_vld, end_rdy;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_banks;
        for (int k = 0; k < NB; k++) bank_rdata[k*32 +: 32] = bank_w[k];
    endtask

    task automatic set_default_banks;
        bank_w[0] = 32'h44332211; bank_w[1] = 32'h88776655;
        bank_w[2] = 32'hCCBBAA99; bank_w[3] = 32'h00FFEEDD;
        apply_banks();
    endtask

    // Reference: lanes form one circular byte array over all banks.
    task automatic model_burst(input int b, input int l, input int n);
        exp_d.delete();
        for (int i = 0; i < n; i++) begin
            int idx;
            idx = (b * LANES + l + i) % (NB * LANES);
            exp_d.push_back(8'(bank_w[idx / LANES] >> (8 * (idx % LANES))));
        end
    endtask

    // Issue one request, then collect every handshaken lane while noise is
    // driven on the request port and out_ready follows mask/random stalls.
    task automatic drive_burst(input int b, input int l, input int n, input int stall_pct,
                               input logic [31:0] stall_mask, input bit swap);
        int cyc;
        bit prev_stall;
        logic [7:0] prev_d;
        logic prev_l;
        got_d.delete(); got_l.delete();
        hold_viol = 0; busy_rdy = 0; timeout = 0;
        prev_stall = 0; prev_d = '0; prev_l = 1'b0;
        req_bank = 2'(b); req_lane = 2'(l); req_len = 5'(n); req_valid = 1'b1; out_ready = 1'b1;
        acc_rdy = req_ready;
        tick();
        if (swap) begin
            for (int k = 0; k < NB; k++) bank_w[k] = bank_w_new[k];
            apply_banks();
        end
        first_vld = out_valid;
        cyc = 0;
        while (got_d.size() < n) begin
            if (cyc > 400) begin timeout = 1; break; end
            req_valid = 1'($urandom_range(1)); req_bank = 2'($urandom);
            req_lane  = 2'($urandom);          req_len  = 5'($urandom);
            out_ready = !(cyc < 32 && stall_mask[cyc]) && ($urandom_range(99) >= 32'(stall_pct));
            if (req_ready) busy_rdy++;
            if (prev_stall && (!out_valid || out_data !== prev_d || out_last !== prev_l)) hold_viol++;
            if (out_valid && out_ready) begin
                got_d.push_back(out_data);
                got_l.push_back(out_last);
            end
            prev_stall = out_valid && !out_ready;
            prev_d = out_data; prev_l = out_last;
            tick();
            cyc++;
        end
        req_valid = 1'b0; out_ready = 1'b1;
        cyc_cnt = cyc + 1;
        end_vld = out_valid; end_rdy = req_ready;
    endtask

    task automatic test_reset;
        #3;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", out_data); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", out_last); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        @(negedge clk); rst_n = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0 || req_ready !== 1'b1) begin errors++;
            $display("FAIL post_reset: valid %b ready %b want 0 1", out_valid, req_ready); end
    endtask

    task automatic test_basic;
        logic [7:0] e [4];
        e = '{8'h11, 8'h22, 8'h33, 8'h44};
        set_default_banks();
        drive_burst(0, 0, 4, 0, 32'h0, 0);
        checks++; if (acc_rdy !== 1'b1) begin errors++; $display("FAIL basic_acc_ready: got %b want 1", acc_rdy); end
        checks++; if (first_vld !== 1'b1) begin errors++; $display("FAIL basic_first_valid: got %b want 1", first_vld); end
        checks++; if (timeout || got_d.size() != 4) begin errors++; $display("FAIL basic_count: got %0d want 4", got_d.size()); end
        for (int i = 0; i < 4 && i < got_d.size(); i++) begin
            checks++; if (got_d[i] !== e[i] || got_l[i] !== (i == 3)) begin errors++;
                $display("FAIL basic_lane%0d: got %h/%b want %h/%b", i, got_d[i], got_l[i], e[i], i == 3); end
        end
        checks++; if (cyc_cnt != 5) begin errors++; $display("FAIL basic_cycles: got %0d want 5", cyc_cnt); end
        checks++; if (end_vld !== 1'b0 || end_rdy !== 1'b1) begin errors++;
            $display("FAIL basic_end: valid %b ready %b want 0 1", end_vld, end_rdy); end
        checks++; if (busy_rdy != 0) begin errors++; $display("FAIL basic_busy_ready: got %0d want 0", busy_rdy); end
    endtask

    task automatic test_bank_wrap;
        logic [7:0] e [4];
        e = '{8'hFF, 8'h00, 8'h11, 8'h22};
        set_default_banks();
        drive_burst(3, 2, 4, 0, 32'h0, 0);
        checks++; if (timeout || got_d.size() != 4) begin errors++; $display("FAIL wrap_count: got %0d want 4", got_d.size()); end
        for (int i = 0; i < 4 && i < got_d.size(); i++) begin
            checks++; if (got_d[i] !== e[i] || got_l[i] !== (i == 3)) begin errors++;
                $display("FAIL wrap_lane%0d: got %h/%b want %h/%b", i, got_d[i], got_l[i], e[i], i == 3); end
        end
    endtask

    task automatic test_backpressure;
        logic [7:0] e [3];
        e = '{8'h55, 8'h66, 8'h77};
        set_default_banks();
        drive_burst(1, 0, 3, 0, 32'h7, 0);
        checks++; if (timeout || got_d.size() != 3) begin errors++; $display("FAIL stall_count: got %0d want 3", got_d.size()); end
        for (int i = 0; i < 3 && i < got_d.size(); i++) begin
            checks++; if (got_d[i] !== e[i] || got_l[i] !== (i == 2)) begin errors++;
                $display("FAIL stall_lane%0d: got %h/%b want %h/%b", i, got_d[i], got_l[i], e[i], i == 2); end
        end
        checks++; if (hold_viol != 0) begin errors++; $display("FAIL stall_hold: got %0d changes want 0", hold_viol); end
        checks++; if (cyc_cnt != 7) begin errors++; $display("FAIL stall_cycles: got %0d want 7", cyc_cnt); end
    endtask

    task automatic test_reject;
        int lens [2];
        lens = '{0, 17};
        for (int i = 0; i < 2; i++) begin
            req_bank = 2'd0; req_lane = 2'd0; req_len = 5'(lens[i]); req_valid = 1'b1;
            tick();
            req_valid = 1'b0;
            checks++; if (err !== 1'b1 || out_valid !== 1'b0 || req_ready !== 1'b1) begin errors++;
                $display("FAIL reject_len%0d: err %b valid %b ready %b want 1 0 1", lens[i], err, out_valid, req_ready); end
            tick();
            checks++; if (err !== 1'b0 || out_valid !== 1'b0) begin errors++;
                $display("FAIL reject_pulse_len%0d: err %b valid %b want 0 0", lens[i], err, out_valid); end
        end
    endtask

    task automatic test_sample_at_load;
        logic [7:0] e0;
        set_default_banks();
        model_burst(0, 1, 3);
        e0 = exp_d[0];
        bank_w_new[0] = 32'hA1B2C3D4; bank_w_new[1] = 32'h0BADF00D;
        bank_w_new[2] = 32'h12345678; bank_w_new[3] = 32'h9ABCDEF0;
        drive_burst(0, 1, 3, 0, 32'h0, 1);
        model_burst(0, 1, 3);
        exp_d[0] = e0;
        checks++; if (timeout || got_d.size() != 3) begin errors++; $display("FAIL sample_count: got %0d want 3", got_d.size()); end
        for (int i = 0; i < 3 && i < got_d.size(); i++) begin
            checks++; if (got_d[i] !== exp_d[i]) begin errors++;
                $display("FAIL sample_lane%0d: got %h want %h", i, got_d[i], exp_d[i]); end
        end
    endtask

    task automatic test_reset_mid_burst;
        set_default_banks();
        req_bank = 2'd0; req_lane = 2'd0; req_len = 5'd8; req_valid = 1'b1; out_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        tick(); tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h33) begin errors++;
            $display("FAIL midrst_lane2: valid %b data %h want 1 33", out_valid, out_data); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0 || req_ready !== 1'b1) begin errors++;
            $display("FAIL midrst_async: valid %b data %h last %b ready %b want 0 00 0 1", out_valid, out_data, out_last, req_ready); end
        @(posedge clk); #3 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (out_valid !== 1'b0 || req_ready !== 1'b1) begin errors++;
                $display("FAIL midrst_after%0d: valid %b ready %b want 0 1", i, out_valid, req_ready); end
        end
    endtask

    task automatic test_random;
        for (int it = 0; it < 40; it++) begin
            int b, l, n;
            for (int k = 0; k < NB; k++) bank_w[k] = $urandom;
            apply_banks();
            if ($urandom_range(4) == 0) begin
                n = ($urandom_range(1) == 0) ? 0 : int'($urandom_range(31, 17));
                req_bank = 2'($urandom); req_lane = 2'($urandom); req_len = 5'(n); req_valid = 1'b1;
                tick();
                req_valid = 1'b0;
                checks++; if (err !== 1'b1 || out_valid !== 1'b0 || req_ready !== 1'b1) begin errors++;
                    $display("FAIL rand_reject%0d: err %b valid %b ready %b want 1 0 1", it, err, out_valid, req_ready); end
                tick();
            end else begin
                b = $urandom_range(NB - 1); l = $urandom_range(LANES - 1); n = $urandom_range(16, 1);
                model_burst(b, l, n);
                drive_burst(b, l, n, 35, 32'h0, 0);
                checks++; if (timeout || got_d.size() != n || hold_viol != 0 || busy_rdy != 0 || !first_vld) begin errors++;
                    $display("FAIL rand_burst%0d: lanes %0d/%0d hold %0d busy %0d first %b", it, got_d.size(), n, hold_viol, busy_rdy, first_vld); end
                for (int i = 0; i < n && i < got_d.size(); i++) begin
                    checks++; if (got_d[i] !== exp_d[i] || got_l[i] !== (i == n - 1)) begin errors++;
                        $display("FAIL rand%0d_lane%0d: got %h/%b want %h/%b", it, i, got_d[i], got_l[i], exp_d[i], i == n - 1); end
                end
                checks++; if (end_vld !== 1'b0 || end_rdy !== 1'b1) begin errors++;
                    $display("FAIL rand_end%0d: valid %b ready %b want 0 1", it, end_vld, end_rdy); end
            end
        end
    endtask

    task automatic test_three_banks;
        bank_rdata3 = {32'hCCBBAA99, 32'h88776655, 32'h44332211};
        out_ready3 = 1'b1;
        req_bank3 = 2'd3; req_lane3 = 2'd0; req_len3 = 5'd2; req_valid3 = 1'b1;
        tick();
        req_valid3 = 1'b0;
        checks++; if (err3 !== 1'b1 || out_valid3 !== 1'b0) begin errors++;
            $display("FAIL nb3_reject: err %b valid %b want 1 0", err3, out_valid3); end
        tick();
        checks++; if (err3 !== 1'b0) begin errors++; $display("FAIL nb3_pulse: err %b want 0", err3); end
        req_bank3 = 2'd2; req_lane3 = 2'd3; req_len3 = 5'd2; req_valid3 = 1'b1;
        tick();
        req_valid3 = 1'b0;
        checks++; if (out_valid3 !== 1'b1 || out_data3 !== 8'hCC || out_last3 !== 1'b0) begin errors++;
            $display("FAIL nb3_lane0: valid %b data %h last %b want 1 cc 0", out_valid3, out_data3, out_last3); end
        tick();
        checks++; if (out_valid3 !== 1'b1 || out_data3 !== 8'h11 || out_last3 !== 1'b1) begin errors++;
            $display("FAIL nb3_lane1: valid %b data %h last %b want 1 11 1", out_valid3, out_data3, out_last3); end
        tick();
        checks++; if (out_valid3 !== 1'b0 || req_ready3 !== 1'b1) begin errors++;
            $display("FAIL nb3_end: valid %b ready %b want 0 1", out_valid3, req_ready3); end
    endtask

    initial begin
        rst_n = 1'b0;
        bank_rdata = '0; req_valid = 1'b0; req_bank = '0; req_lane = '0; req_len = '0; out_ready = 1'b1;
        bank_rdata3 = '0; req_valid3 = 1'b0; req_bank3 = '0; req_lane3 = '0; req_len3 = '0; out_ready3 = 1'b1;
        #20;
        test_reset();
        test_basic();
        test_bank_wrap();
        test_backpressure();
        test_reject();
        test_sample_at_load();
        test_reset_mid_burst();
        test_random();
        test_three_banks();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
